// File: rtl/btn_uart_pkg.sv
// Shared types and constants for the button-event UART reporter.
// RELEASE_REPORT_EN compiles in the RELEASE message constant.
package btn_uart_pkg;

    typedef enum logic {
        EV_PRESS   = 1'b0,
        EV_RELEASE = 1'b1
    } ev_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } ctl_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_ACTIVE
    } tx_state_e;

    localparam logic [7:0] CH_P  = 8'h50;
`ifdef RELEASE_REPORT_EN
    localparam logic [7:0] CH_R  = 8'h52;
`endif
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam int unsigned MSG_LEN = 3;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, idle high; one load cycle precedes the start bit.
module uart_tx_byte
    import btn_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 2604
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_tx
);

    localparam int unsigned    CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     BIT_STOP = 4'd9;
    localparam logic [3:0]     BIT_D7   = 4'd8;

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             tx_q, tx_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    // tx_q is registered, so the value loaded here is the bit shown for the
    // next CLKS_PER_BIT clocks; bit_q names the bit currently on the line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        o_ready = (state_q == TX_IDLE);
        o_done  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (i_valid) begin
                    sh_d    = i_data;
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                tx_d    = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = TX_ACTIVE;
            end
            TX_ACTIVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == BIT_STOP) begin
                        o_done  = 1'b1;
                        tx_d    = 1'b1;
                        state_d = TX_IDLE;
                    end else if (bit_q == BIT_D7) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d = sh_q[0];
                        sh_d = {1'b0, sh_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign o_tx = tx_q;

endmodule

// File: rtl/btn_event_uart_reporter.sv
// Button edge detector, event queue and message sequencer driving uart_tx_byte.
// Define RELEASE_REPORT_EN to also report falling edges as "R\r\n".
module btn_event_uart_reporter
    import btn_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 2604,
    parameter int unsigned QUEUE_DEPTH  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clean_switch,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_overflow,
    output logic [7:0] o_event_count
);

    localparam int unsigned      PTR_W    = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
    localparam logic [1:0]       LAST_IDX = 2'(MSG_LEN - 1);

    logic           prev_sw_q;
    logic           ev_valid;
    logic           full;
    logic           push_ok;
    logic           ovf_set;
    logic           pop;
    logic [PTR_W:0] lvl_q, lvl_d;
    logic [7:0]     evcnt_q;
    logic           ovf_q;

    ctl_state_e     state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic           tx_valid;
    logic           tx_ready;
    logic           tx_done;
    logic [7:0]     tx_byte;
    logic [7:0]     first_byte;

`ifdef RELEASE_REPORT_EN
    ev_code_e         ev_code;
    ev_code_e         mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    ev_code_e         code_q;

    always_comb begin
        ev_valid = i_clean_switch ^ prev_sw_q;
        ev_code  = i_clean_switch ? EV_PRESS : EV_RELEASE;
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= ev_code;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            code_q <= EV_PRESS;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
                code_q <= mem_q[rptr_q];
            end
        end
    end

    assign first_byte = (code_q == EV_RELEASE) ? CH_R : CH_P;
`else
    // Every queued event is a press, so the queue reduces to an occupancy count.
    assign ev_valid   = i_clean_switch & ~prev_sw_q;
    assign first_byte = CH_P;
`endif

    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    always_comb begin
        full    = (lvl_q == FULL_LVL);
        push_ok = ev_valid & (~full | pop);
        ovf_set = ev_valid & full & ~pop;
        lvl_d   = lvl_q;
        case ({push_ok, pop})
            2'b10:   lvl_d = lvl_q + LVL_ONE;
            2'b01:   lvl_d = lvl_q - LVL_ONE;
            default: lvl_d = lvl_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pop      = 1'b0;
        tx_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lvl_q != '0) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (idx_q)
            2'd0:    tx_byte = first_byte;
            2'd1:    tx_byte = CH_CR;
            default: tx_byte = CH_LF;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_sw_q <= 1'b0;
            lvl_q     <= '0;
            evcnt_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
            idx_q     <= '0;
        end else begin
            prev_sw_q <= i_clean_switch;
            lvl_q     <= lvl_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            if (push_ok) begin
                evcnt_q <= evcnt_q + 8'd1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(tx_valid),
        .i_data (tx_byte),
        .o_ready(tx_ready),
        .o_done (tx_done),
        .o_tx   (o_uart_tx)
    );

    assign o_busy        = (state_q != ST_IDLE) | (lvl_q != '0);
    assign o_overflow    = ovf_q;
    assign o_event_count = evcnt_q;

endmodule

// File: tb/tb_btn_event_uart_reporter.sv
// Directed bench for btn_event_uart_reporter with CLKS_PER_BIT=4, QUEUE_DEPTH=4.
// Expectations follow RELEASE_REPORT_EN when it is defined for the build.
module tb_btn_event_uart_reporter;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw  = 1'b0;
    logic       tx;
    logic       busy;
    logic       ovf;
    logic [7:0] evcnt;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [7:0] rxq [$];
    int         rxt [$];
    int         rx_ferr = 0;
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    int         rx_start = 0;
    logic [7:0] rx_sh = '0;

    btn_event_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .QUEUE_DEPTH (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clean_switch(sw),
        .o_uart_tx     (tx),
        .o_busy        (busy),
        .o_overflow    (ovf),
        .o_event_count (evcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder sampling mid-bit on the falling clock edge.
    always @(negedge clk) begin
        if (rst) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act   <= 1'b1;
                rx_cnt   <= 1;
                rx_start <= cyc;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
                rx_sh <= {tx, rx_sh[7:1]};
            if (rx_cnt == 38) begin
                rxq.push_back(rx_sh);
                rxt.push_back(rx_start);
                if (tx !== 1'b1) rx_ferr <= rx_ferr + 1;
                rx_act <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        sw  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rxq.delete();
        rxt.delete();
        rx_ferr = 0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else passed++;
        checks++; if (evcnt !== 8'd0) $display("FAIL reset_count: got %0d expected 0", evcnt); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single_press();
        logic [7:0] exp_b [$];
        logic [7:0] got;
        do_reset();
        exp_b = '{8'h50, 8'h0D, 8'h0A};
        sw = 1'b1;
        @(posedge clk); #1;
        checks++; if (evcnt !== 8'd1) $display("FAIL sp_push_count: got %0d expected 1", evcnt); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL sp_busy_at_push: got %b expected 1", busy); else passed++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (tx !== 1'b1) $display("FAIL sp_tx_e2: got %b expected 1", tx); else passed++;
        @(posedge clk); #1;
        checks++; if (tx !== 1'b0) $display("FAIL sp_start_e3: got %b expected 0", tx); else passed++;
        repeat (197) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL sp_busy_after: got %b expected 0", busy); else passed++;
        checks++; if (evcnt !== 8'd1) $display("FAIL sp_count: got %0d expected 1", evcnt); else passed++;
        checks++; if (rxq.size() !== 3) $display("FAIL sp_nbytes: got %0d expected 3", rxq.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) $display("FAIL sp_byte%0d: got %h expected %h", i, got, exp_b[i]); else passed++;
        end
        checks++; if (rx_ferr !== 0) $display("FAIL sp_framing: got %0d expected 0", rx_ferr); else passed++;
    endtask

    task automatic test_press_release();
        logic [7:0] exp_b [$];
        logic [7:0] got;
        bit         ok;
        int         exp_cnt;
        do_reset();
`ifdef RELEASE_REPORT_EN
        exp_b   = '{8'h50, 8'h0D, 8'h0A, 8'h52, 8'h0D, 8'h0A};
        exp_cnt = 2;
`else
        exp_b   = '{8'h50, 8'h0D, 8'h0A};
        exp_cnt = 1;
`endif
        sw = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sw = 1'b0;
        wait_idle(800, ok);
        checks++; if (!ok) $display("FAIL pr_timeout: got busy expected idle"); else passed++;
        checks++; if (evcnt !== 8'(exp_cnt)) $display("FAIL pr_count: got %0d expected %0d", evcnt, exp_cnt); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL pr_ovf: got %b expected 0", ovf); else passed++;
        checks++; if (rxq.size() !== exp_b.size()) $display("FAIL pr_nbytes: got %0d expected %0d", rxq.size(), exp_b.size()); else passed++;
        for (int i = 0; i < exp_b.size(); i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) $display("FAIL pr_byte%0d: got %h expected %h", i, got, exp_b[i]); else passed++;
        end
        if (rxt.size() >= 3) begin
            checks++; if (rxt[1] - rxt[0] !== 42) $display("FAIL pr_byte_gap: got %0d expected 42", rxt[1] - rxt[0]); else passed++;
            checks++; if (rxt[2] - rxt[1] !== 42) $display("FAIL pr_byte_gap2: got %0d expected 42", rxt[2] - rxt[1]); else passed++;
        end else begin
            checks++; $display("FAIL pr_gap_bytes: got %0d bytes expected at least 3", rxt.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b [$];
        logic [7:0] got;
        bit         ok;
        int         exp_cnt;
        logic       exp_ovf;
        do_reset();
`ifdef RELEASE_REPORT_EN
        exp_cnt = 5;
        exp_ovf = 1'b1;
        exp_b = '{8'h50, 8'h0D, 8'h0A, 8'h52, 8'h0D, 8'h0A, 8'h50, 8'h0D, 8'h0A,
                  8'h52, 8'h0D, 8'h0A, 8'h50, 8'h0D, 8'h0A};
`else
        exp_cnt = 3;
        exp_ovf = 1'b0;
        exp_b = '{8'h50, 8'h0D, 8'h0A, 8'h50, 8'h0D, 8'h0A, 8'h50, 8'h0D, 8'h0A};
`endif
        for (int k = 0; k < 6; k++) begin
            sw = ((k % 2) == 0);
            repeat (10) @(posedge clk);
            #1;
        end
        checks++; if (ovf !== exp_ovf) $display("FAIL ov_flag_early: got %b expected %b", ovf, exp_ovf); else passed++;
        checks++; if (evcnt !== 8'(exp_cnt)) $display("FAIL ov_count_early: got %0d expected %0d", evcnt, exp_cnt); else passed++;
        wait_idle(1500, ok);
        checks++; if (!ok) $display("FAIL ov_timeout: got busy expected idle"); else passed++;
        checks++; if (ovf !== exp_ovf) $display("FAIL ov_flag_sticky: got %b expected %b", ovf, exp_ovf); else passed++;
        checks++; if (evcnt !== 8'(exp_cnt)) $display("FAIL ov_count: got %0d expected %0d", evcnt, exp_cnt); else passed++;
        checks++; if (rxq.size() !== exp_b.size()) $display("FAIL ov_nbytes: got %0d expected %0d", rxq.size(), exp_b.size()); else passed++;
        for (int i = 0; i < exp_b.size(); i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) $display("FAIL ov_byte%0d: got %h expected %h", i, got, exp_b[i]); else passed++;
        end
        if (rxt.size() >= 4) begin
            checks++; if (rxt[3] - rxt[2] !== 43) $display("FAIL ov_msg_gap: got %0d expected 43", rxt[3] - rxt[2]); else passed++;
        end else begin
            checks++; $display("FAIL ov_gap_bytes: got %0d bytes expected at least 4", rxt.size());
        end
        checks++; if (rx_ferr !== 0) $display("FAIL ov_framing: got %0d expected 0", rx_ferr); else passed++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp_b [$];
        logic [7:0] got;
        bit         ok;
        do_reset();
        exp_b = '{8'h50, 8'h0D, 8'h0A};
        sw = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b0) $display("FAIL rm_data_bit3: got %b expected 0", tx); else passed++;
        rst = 1'b1;
        sw  = 1'b0;
        @(posedge clk); #1;
        checks++; if (tx !== 1'b1) $display("FAIL rm_tx: got %b expected 1", tx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b expected 0", busy); else passed++;
        checks++; if (evcnt !== 8'd0) $display("FAIL rm_count: got %0d expected 0", evcnt); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL rm_ovf: got %b expected 0", ovf); else passed++;
        rst = 1'b0;
        rxq.delete();
        rxt.delete();
        rx_ferr = 0;
        repeat (50) @(posedge clk);
        #1;
        checks++; if (rxq.size() !== 0) $display("FAIL rm_quiet: got %0d bytes expected 0", rxq.size()); else passed++;
        sw = 1'b1;
        @(posedge clk); #1;
        wait_idle(400, ok);
        checks++; if (!ok) $display("FAIL rm_timeout: got busy expected idle"); else passed++;
        checks++; if (rxq.size() !== 3) $display("FAIL rm_nbytes: got %0d expected 3", rxq.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) $display("FAIL rm_byte%0d: got %h expected %h", i, got, exp_b[i]); else passed++;
        end
        checks++; if (evcnt !== 8'd1) $display("FAIL rm_count_after: got %0d expected 1", evcnt); else passed++;
    endtask

    task automatic one_event();
`ifdef RELEASE_REPORT_EN
        sw = ~sw;
        @(posedge clk); #1;
`else
        sw = 1'b1;
        @(posedge clk); #1;
        sw = 1'b0;
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_count_wrap();
        bit ok;
        bit timed_out;
        do_reset();
        timed_out = 1'b0;
        for (int i = 0; i < 255; i++) begin
            one_event();
            wait_idle(300, ok);
            if (!ok) begin
                timed_out = 1'b1;
                break;
            end
        end
        checks++; if (timed_out) $display("FAIL cw_timeout: got busy expected idle"); else passed++;
        checks++; if (evcnt !== 8'd255) $display("FAIL cw_count_255: got %0d expected 255", evcnt); else passed++;
        one_event();
        wait_idle(300, ok);
        checks++; if (evcnt !== 8'd0) $display("FAIL cw_count_wrap: got %0d expected 0", evcnt); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL cw_ovf: got %b expected 0", ovf); else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_press();
        test_press_release();
        test_overflow();
        test_reset_midframe();
        test_count_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
